m_stage_data_mem: RTL and testbench
===================================

Name: m_stage_data_mem

Overview:
- Memory-stage data memory of the 5-stage pipeline. Consumes the M-stage ALU address, the store data and the decoded access size.
- Produces ReadData_M, which the M/W pipeline register latches for writeback.
- Supports word, halfword and byte stores, plus signed and unsigned loads.
- Little-endian storage, synchronous write, asynchronous read, and alignment and range error flags.

Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words in the array.
- ADDR_W, 32: width of the byte address input.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mem_we  input  1  store enable for this cycle.
- mem_size  input  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned, 5-7 reserved.
- addr  input  ADDR_W  byte address (ALUOut_M).
- wdata  input  32  store data (forwarded rt value).
- pc  input  32  M-stage PC, used only for the write trace.
- rdata  output  32  extended load result (ReadData_M).
- align_err  output  1  current access is misaligned.
- range_err  output  1  current access is out of range.
- wr_valid  output  1  registered pulse: a store committed on the previous edge.
- wr_addr  output  32  registered word-aligned address of the committed store.
- wr_word  output  32  registered full post-merge word of the committed store.
- wr_pc  output  32  registered pc of the committed store.

Behaviour:
- **Reset.** On a clk edge with reset=1, every array word becomes 0, and wr_valid, wr_addr, wr_word and wr_pc become 0. Any store in the same cycle is dropped. Initial contents are also all-zero.
- **Index and range.** word index = addr[ADDR_W-1:2]. range_err = (addr >= DEPTH_WORDS*4).
- **Alignment.**
  - Word: align_err = (addr[1:0] != 0).
  - Half: align_err = addr[0].
  - Byte: never misaligned.
  - Reserved mem_size: treat as align_err=1.
- **Read (combinational, zero latency).** word = array[index]. Lane selection:
  - Half: uses addr[1]; lane 0 = bits 15:0.
  - Byte: uses addr[1:0]; lane 0 = bits 7:0.
  - Signed types sign-extend; unsigned types zero-extend.
  - If align_err or range_err, rdata = 0.
  - rdata reflects array contents before any store at the coming edge; there is no same-cycle bypass.
- **Write (at posedge, when mem_we=1, reset=0, align_err=0, range_err=0).**
  - Word: replaces the whole word.
  - Half: replaces the 16-bit lane at addr[1] with wdata[15:0].
  - Byte: replaces the 8-bit lane at addr[1:0] with wdata[7:0].
  - Other lanes are preserved.
  - mem_size 1/2 are equivalent for stores, as are 3/4.
  - A faulting store changes nothing.
- **Trace.**
  - wr_valid is 1 for exactly the cycle after a committed store; otherwise 0.
  - wr_addr = {addr[31:2],2'b00}.
  - wr_word = the merged word now in the array.
  - wr_pc = pc.
  - Back-to-back stores give consecutive wr_valid=1 cycles with the respective values.
- **Mid-operation reset.** A reset asserted while stores are in flight clears the array, the trace outputs and any pending commit at the same edge.
- **No handshake.** Every access completes in its cycle; the block never stalls the pipeline.

Decomposition:
- Shared package:
  - mem_size encodings (SZ_W, SZ_HS, SZ_HU, SZ_BS, SZ_BU).
  - DEPTH_WORDS default.
  - Helper functions for lane select and sign/zero extension, which the W stage reuses if the extension is later moved there.
- One sub-module, dm_lane_merge: given old word, wdata, mem_size and addr[1:0], it returns the merged word and the 4-bit byte-enable. It is purely combinational.
- The array, reset clear and trace registers stay in the top module.

Test Plan:
- **Word round trip.** After reset, store size 0 to addr 0x10 with 0xDEADBEEF. → wr_valid=1 next cycle, wr_word=0xDEADBEEF, wr_pc echoed. A size-0 load at 0x10 then gives rdata=0xDEADBEEF.
- **Byte lanes and extension.**
  - Byte store of 0x80 to 0x11, then 0x7F to 0x13. → word at 0x10 = 0x7FAD80EF.
  - Loads at 0x11: size 3 gives 0xFFFFFF80; size 4 gives 0x00000080.
- **Half lanes.**
  - Half store of 0x1234 to 0x22 over a zero word. → word = 0x12340000.
  - Size 1 load at 0x22 gives 0x00001234.
  - After a half store of 0x8001 to 0x20: size 1 load at 0x20 gives 0xFFFF8001; size 2 gives 0x00008001.
- **Faults.**
  - Word store to 0x12, half store to 0x21, and any store to addr 0x3000 (DEPTH_WORDS*4).
  - → align_err or range_err=1, rdata=0, wr_valid stays 0, and array contents are unchanged on readback.
- **Same-cycle read/write.** Load and store to 0x40 in one cycle (old=5, new=9). → rdata=5 that cycle and 9 the next.
- **Reset mid-stream.** Three back-to-back word stores with reset asserted on the third edge. → wr_valid drops to 0, all three locations read 0, and wr_addr/wr_word/wr_pc are 0.

Source files
------------

// File: rtl/m_stage_data_mem_pkg.sv
// Shared definitions for the M-stage data memory: access-size encodings and
// load lane-select / extension helpers that the W stage can reuse.
package m_stage_data_mem_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 3072;

    // Access size as decoded in ID; codes 5..7 are reserved.
    typedef enum logic [2:0] {
        SZ_W  = 3'd0,
        SZ_HS = 3'd1,
        SZ_HU = 3'd2,
        SZ_BS = 3'd3,
        SZ_BU = 3'd4
    } mem_size_e;

    function automatic logic is_half(input logic [2:0] sz);
        return (sz == SZ_HS) || (sz == SZ_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] sz);
        return (sz == SZ_BS) || (sz == SZ_BU);
    endfunction

    function automatic logic is_signed_ld(input logic [2:0] sz);
        return (sz == SZ_HS) || (sz == SZ_BS);
    endfunction

    // Little-endian halfword lane: sel=0 picks bits 15:0.
    function automatic logic [15:0] lane_half(input logic [31:0] word, input logic sel);
        return sel ? word[31:16] : word[15:0];
    endfunction

    // Little-endian byte lane: off=0 picks bits 7:0.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Full load result for a given size; reserved sizes return zero.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  sz,
                                                input logic [1:0]  off);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane_half(word, off[1]);
        b = lane_byte(word, off);
        if (sz == SZ_W) begin
            return word;
        end else if (is_half(sz)) begin
            return is_signed_ld(sz) ? {{16{h[15]}}, h} : {16'h0000, h};
        end else if (is_byte(sz)) begin
            return is_signed_ld(sz) ? {{24{b[7]}}, b} : {24'h000000, b};
        end
        return 32'h0000_0000;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Store lane merge: combines the current memory word with store data for a
// word, halfword or byte store and reports which bytes are written.
module dm_lane_merge
    import m_stage_data_mem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_mem_size,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_merged,
    output logic [3:0]  o_be
);

    logic [31:0] w_repl;

    // Replicate the store data across lanes and derive byte enables.
    always_comb begin
        w_repl = i_wdata;
        o_be   = 4'b0000;
        if (i_mem_size == SZ_W) begin
            w_repl = i_wdata;
            o_be   = 4'b1111;
        end else if (is_half(i_mem_size)) begin
            w_repl = {2{i_wdata[15:0]}};
            o_be   = i_byte_off[1] ? 4'b1100 : 4'b0011;
        end else if (is_byte(i_mem_size)) begin
            w_repl = {4{i_wdata[7:0]}};
            o_be   = 4'b0001 << i_byte_off;
        end
    end

    // Byte-wise select between new and preserved lanes.
    always_comb begin
        o_merged = i_old_word;
        for (int k = 0; k < 4; k++) begin
            if (o_be[k]) begin
                o_merged[8*k +: 8] = w_repl[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/m_stage_data_mem.sv
// M-stage data memory: little-endian word array with synchronous write,
// combinational read, alignment/range checks and a registered store trace.
// Assumes ADDR_W >= 32 so the trace address can be taken from addr[31:2].
module m_stage_data_mem
    import m_stage_data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [2:0]        mem_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       pc,
    output logic [31:0]       rdata,
    output logic              align_err,
    output logic              range_err,
    output logic              wr_valid,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_word,
    output logic [31:0]       wr_pc
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned MEM_BYTES = DEPTH_WORDS * 4;

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic              r_wr_valid;
    logic [31:0]       r_wr_addr;
    logic [31:0]       r_wr_word;
    logic [31:0]       r_wr_pc;

    logic [IDX_W-1:0]  w_index;
    logic [31:0]       w_old_word;
    logic [31:0]       w_merged;
    logic [3:0]        w_be;
    logic              w_align_err;
    logic              w_range_err;
    logic              w_commit;

    assign w_index     = addr[IDX_W+1:2];
    assign w_range_err = ({1'b0, addr} >= (ADDR_W + 1)'(MEM_BYTES));
    // Out-of-range indices may exceed the array, so never read them.
    assign w_old_word  = w_range_err ? 32'h0000_0000 : r_mem[w_index];
    assign w_commit    = mem_we && !w_align_err && !w_range_err;

    // Alignment check per access size; reserved sizes always fault.
    always_comb begin
        w_align_err = 1'b1;
        if (mem_size == SZ_W) begin
            w_align_err = (addr[1:0] != 2'b00);
        end else if (is_half(mem_size)) begin
            w_align_err = addr[0];
        end else if (is_byte(mem_size)) begin
            w_align_err = 1'b0;
        end
    end

    dm_lane_merge u_lane_merge (
        .i_old_word (w_old_word),
        .i_wdata    (wdata),
        .i_mem_size (mem_size),
        .i_byte_off (addr[1:0]),
        .o_merged   (w_merged),
        .o_be       (w_be)
    );

    // Load path: pre-write contents, zeroed on any fault.
    always_comb begin
        rdata = 32'h0000_0000;
        if (!w_align_err && !w_range_err) begin
            rdata = extend_load(w_old_word, mem_size, addr[1:0]);
        end
    end

    // Array: reset clears every word; otherwise commit the merged store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_commit && (w_be != 4'b0000)) begin
            r_mem[w_index] <= w_merged;
        end
    end

    // Store trace: one-cycle valid pulse; payload holds until the next commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 32'h0000_0000;
            r_wr_word  <= 32'h0000_0000;
            r_wr_pc    <= 32'h0000_0000;
        end else begin
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_addr <= {addr[31:2], 2'b00};
                r_wr_word <= w_merged;
                r_wr_pc   <= pc;
            end
        end
    end

    assign align_err = w_align_err;
    assign range_err = w_range_err;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_word   = r_wr_word;
    assign wr_pc     = r_wr_pc;

endmodule

// File: tb/tb_m_stage_data_mem.sv
// Self-checking bench for m_stage_data_mem: directed plan followed by random
// traffic, compared against a byte-addressed reference memory.
module tb_m_stage_data_mem;

    localparam int unsigned DEPTH  = 3072;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        align_err;
    logic        range_err;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_word;
    logic [31:0] wr_pc;

    m_stage_data_mem dut (
        .clk       (clk),
        .reset     (reset),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .rdata     (rdata),
        .align_err (align_err),
        .range_err (range_err),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_word   (wr_word),
        .wr_pc     (wr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory as plain bytes, little-endian.
    logic [7:0]  mbytes [NBYTES];
    int          n_vec;
    int          n_err;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_range(input logic [31:0] a);
        return a >= NBYTES;
    endfunction

    function automatic logic ref_align(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0:       return a % 4 != 0;
            3'd1, 3'd2: return a % 2 != 0;
            3'd3, 3'd4: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'd3;
        return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        if (ref_align(sz, a) || ref_range(a)) return 32'h0;
        case (sz)
            3'd0: return {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
            3'd1: begin h = {mbytes[a+1], mbytes[a]}; return 32'(signed'(h)); end
            3'd2: begin h = {mbytes[a+1], mbytes[a]}; return {16'h0, h}; end
            3'd3: begin b = mbytes[a]; return 32'(signed'(b)); end
            default: begin b = mbytes[a]; return {24'h0, b}; end
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(NBYTES); i++) mbytes[i] = 8'h00;
    endtask

    // One cycle: drive, check combinational outputs, clock, check trace.
    task automatic step(input logic rst, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p);
        logic ok;
        reset = rst; mem_we = we; mem_size = sz; addr = a; wdata = wd; pc = p;
        #1;
        chk("rdata", rdata, ref_load(sz, a));
        chk("align_err", {31'b0, align_err}, {31'b0, ref_align(sz, a)});
        chk("range_err", {31'b0, range_err}, {31'b0, ref_range(a)});
        last_rdata = rdata;
        ok = we && !rst && !ref_align(sz, a) && !ref_range(a);
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
            chk("wr_valid_rst", {31'b0, wr_valid}, 32'h0);
            chk("wr_addr_rst", wr_addr, 32'h0);
            chk("wr_word_rst", wr_word, 32'h0);
            chk("wr_pc_rst", wr_pc, 32'h0);
        end else if (ok) begin
            if (sz == 3'd0) begin
                for (int k = 0; k < 4; k++) mbytes[a+k] = wd[8*k +: 8];
            end else if (sz == 3'd1 || sz == 3'd2) begin
                mbytes[a] = wd[7:0];
                mbytes[a+1] = wd[15:8];
            end else begin
                mbytes[a] = wd[7:0];
            end
            chk("wr_valid", {31'b0, wr_valid}, 32'h1);
            chk("wr_addr", wr_addr, a & ~32'd3);
            chk("wr_word", wr_word, ref_word(a));
            chk("wr_pc", wr_pc, p);
        end else begin
            chk("wr_valid_idle", {31'b0, wr_valid}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        n_vec = 0;
        n_err = 0;
        last_rdata = 32'h0;
        reset = 1'b1; mem_we = 1'b0; mem_size = 3'd0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
        model_clear();
        @(posedge clk);
        #1;
        chk("reset_wr_valid", {31'b0, wr_valid}, 32'h0);
        chk("reset_wr_word", wr_word, 32'h0);

        // Word round trip
        step(1'b0, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0040_0100);
        step(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0);
        chk("word_rt", last_rdata, 32'hDEADBEEF);

        // Byte lanes and extension
        step(1'b0, 1'b1, 3'd3, 32'h11, 32'h0000_0080, 32'h0040_0104);
        step(1'b0, 1'b1, 3'd4, 32'h13, 32'h0000_007F, 32'h0040_0108);
        step(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0);
        chk("byte_merge", last_rdata, 32'h7FAD80EF);
        step(1'b0, 1'b0, 3'd3, 32'h11, 32'h0, 32'h0);
        chk("byte_sext", last_rdata, 32'hFFFFFF80);
        step(1'b0, 1'b0, 3'd4, 32'h11, 32'h0, 32'h0);
        chk("byte_zext", last_rdata, 32'h00000080);

        // Half lanes
        step(1'b0, 1'b1, 3'd1, 32'h22, 32'hAAAA_1234, 32'h0040_010C);
        step(1'b0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h0);
        chk("half_hi", last_rdata, 32'h12340000);
        step(1'b0, 1'b0, 3'd1, 32'h22, 32'h0, 32'h0);
        chk("half_ld", last_rdata, 32'h00001234);
        step(1'b0, 1'b1, 3'd2, 32'h20, 32'h0000_8001, 32'h0040_0110);
        step(1'b0, 1'b0, 3'd1, 32'h20, 32'h0, 32'h0);
        chk("half_sext", last_rdata, 32'hFFFF8001);
        step(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h0);
        chk("half_zext", last_rdata, 32'h00008001);

        // Faults
        step(1'b0, 1'b1, 3'd0, 32'h12, 32'h1111_1111, 32'h0040_0114);
        chk("fault_w_rdata", last_rdata, 32'h0);
        step(1'b0, 1'b1, 3'd1, 32'h21, 32'h2222_2222, 32'h0040_0118);
        step(1'b0, 1'b1, 3'd0, 32'h3000, 32'h3333_3333, 32'h0040_011C);
        step(1'b0, 1'b1, 3'd6, 32'h20, 32'h4444_4444, 32'h0040_0120);
        step(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0);
        chk("fault_keep10", last_rdata, 32'h7FAD80EF);
        step(1'b0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h0);
        chk("fault_keep20", last_rdata, 32'h12348001);

        // Same-cycle read/write
        step(1'b0, 1'b1, 3'd0, 32'h40, 32'd5, 32'h0040_0124);
        step(1'b0, 1'b1, 3'd0, 32'h40, 32'd9, 32'h0040_0128);
        chk("rw_old", last_rdata, 32'd5);
        step(1'b0, 1'b0, 3'd0, 32'h40, 32'h0, 32'h0);
        chk("rw_new", last_rdata, 32'd9);

        // Reset mid-stream
        step(1'b0, 1'b1, 3'd0, 32'h50, 32'hA5A5_0001, 32'h0040_0200);
        step(1'b0, 1'b1, 3'd0, 32'h54, 32'hA5A5_0002, 32'h0040_0204);
        step(1'b1, 1'b1, 3'd0, 32'h58, 32'hA5A5_0003, 32'h0040_0208);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 32'h50 + 32'(4 * i), 32'h0, 32'h0);
            chk("rst_clear", last_rdata, 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) a = 32'($urandom_range(0, 127));
            else if (r < 9) a = 32'h2FF8 + 32'($urandom_range(0, 15));
            else a = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), sz, a, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
